// File: rtl/cia_pkg.sv
// cia_pkg
//   Shared definitions for the pipelined carry-increment adder.
//   - MODE_ADD / MODE_SUB : encodings of the 'sub' operation select input.
//   - cia_params_ok()     : elaboration-time legality check of WIDTH/BLOCK/STAGES.
package cia_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Legal when BLOCK divides WIDTH, WIDTH >= 4, and STAGES is a divisor of
  // the lane count in the range 1..LANES.
  function automatic bit cia_params_ok(input int width, input int block, input int stages);
    bit ok;
    int lanes;
    ok    = 1'b1;
    lanes = 0;
    if (block < 1 || width < 4) begin
      ok = 1'b0;
    end else if ((width % block) != 0) begin
      ok = 1'b0;
    end else begin
      lanes = width / block;
      if (stages < 1 || stages > lanes || (lanes % stages) != 0) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/cia_block.sv
// cia_block
//   One carry-increment lane: a BLOCK-bit ripple sum computed with carry-in 0,
//   followed by a half-adder chain that increments that sum by the lane carry-in.
//   The lane carry-out is the OR of the ripple carry and the increment carry
//   (at most one of them can be set).
// Ports:
//   a, b  in  BLOCK  lane operands (b already inverted for subtraction)
//   ci    in  1      lane carry-in
//   sum   out BLOCK  lane sum
//   co    out 1      lane carry-out
module cia_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] sum,
  output logic             co
);

  // Chains are walked with blocking temporaries so the carry path is a plain
  // combinational sequence rather than a self-referencing vector.
  always_comb begin
    logic rc;
    logic ic;
    logic raw;
    rc  = 1'b0;
    ic  = ci;
    raw = 1'b0;
    sum = '0;
    for (int n = 0; n < BLOCK; n++) begin
      raw    = a[n] ^ b[n] ^ rc;
      rc     = (a[n] & b[n]) | (rc & (a[n] ^ b[n]));
      sum[n] = raw ^ ic;
      ic     = raw & ic;
    end
    co = rc | ic;
  end

endmodule

// File: rtl/pipelined_cia_adder.sv
// pipelined_cia_adder
//   WIDTH-bit adder/subtractor built from LANES carry-increment lanes spread
//   evenly over STAGES pipeline stages. Each stage processes its lanes from
//   the carry registered by the previous stage, forwarding the unprocessed
//   operand bits and the completed sum bits. A single global advance signal
//   (adv = !out_valid | out_ready) enables every register, so the pipe
//   either moves as a whole or holds as a whole.
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      operands present
//   in_ready   out 1      operands accepted this cycle (== adv)
//   a, b       in  WIDTH  operands
//   cin        in  1      carry in (ignored when sub=1)
//   sub        in  1      0: a+b+cin, 1: a-b
//   out_valid  out 1      result present
//   out_ready  in  1      consumer accepts result
//   sum        out WIDTH  result, modulo 2^WIDTH
//   cout       out 1      carry out (subtract: 1 = no borrow)
//   ovf        out 1      signed overflow
module pipelined_cia_adder
  import cia_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LANES = WIDTH / BLOCK;
  localparam int LPS   = LANES / STAGES;  // lanes handled per stage
  localparam int SB    = LPS * BLOCK;     // bits handled per stage

  if (!cia_params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
    $error("pipelined_cia_adder: illegal WIDTH/BLOCK/STAGES combination");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
    localparam int LO = gs * SB;  // first bit handled by this stage
    localparam int HI = LO + SB;  // bits completed after this stage

    logic                v_in;
    logic                c_in;
    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic [SB-1:0]       lane_sum;
    logic [HI-1:0]       s_next;
    logic                c_out;

    logic                v_reg;
    logic                c_reg;
    logic [HI-1:0]       s_reg;

    if (gs == 0) begin : g_head
      // Subtraction is folded in here: B inverted and the first lane carry
      // forced to 1, so later stages only ever see an addition.
      assign v_in   = in_valid;
      assign a_in   = a;
      assign b_in   = (sub == MODE_ADD) ? b : ~b;
      assign c_in   = (sub == MODE_SUB) ? 1'b1 : cin;
      assign s_next = lane_sum;
    end else begin : g_body
      assign v_in   = g_stage[gs-1].v_reg;
      assign a_in   = g_stage[gs-1].g_fwd.a_reg;
      assign b_in   = g_stage[gs-1].g_fwd.b_reg;
      assign c_in   = g_stage[gs-1].c_reg;
      assign s_next = {lane_sum, g_stage[gs-1].s_reg};
    end

    for (genvar gl = 0; gl < LPS; gl++) begin : g_lane
      logic ci;
      logic co;
      if (gl == 0) begin : g_cfirst
        assign ci = c_in;
      end else begin : g_cnext
        assign ci = g_lane[gl-1].co;
      end
      cia_block #(
        .BLOCK(BLOCK)
      ) u_block (
        .a  (a_in[gl*BLOCK +: BLOCK]),
        .b  (b_in[gl*BLOCK +: BLOCK]),
        .ci (ci),
        .sum(lane_sum[gl*BLOCK +: BLOCK]),
        .co (co)
      );
    end

    assign c_out = g_lane[LPS-1].co;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
        s_reg <= '0;
      end else if (adv) begin
        v_reg <= v_in;
        c_reg <= c_out;
        s_reg <= s_next;
      end
    end

    // Operand bits not yet consumed travel with the partial result.
    if (gs < STAGES - 1) begin : g_fwd
      localparam int REM = WIDTH - HI;
      logic [REM-1:0] a_reg;
      logic [REM-1:0] b_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv) begin
          a_reg <= a_in[WIDTH-LO-1:SB];
          b_reg <= b_in[WIDTH-LO-1:SB];
        end
      end
    end

    // The MSB lives in the last stage: a^b^sum at the MSB recovers the carry
    // into the MSB, which XORed with the carry out gives signed overflow.
    if (gs == STAGES - 1) begin : g_last
      logic ovf_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (adv) begin
          ovf_reg <= a_in[SB-1] ^ b_in[SB-1] ^ lane_sum[SB-1] ^ c_out;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_reg;
  assign sum       = g_stage[STAGES-1].s_reg;
  assign cout      = g_stage[STAGES-1].c_reg;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_cia_adder.sv
// tb_pipelined_cia_adder
//   Randomized and directed stimulus against an arithmetic reference model
//   (plain integer add/subtract, sign-rule overflow) with an in-order
//   scoreboard queue, latency tracking and reset/stall scenarios.
module tb_pipelined_cia_adder;

  localparam int W      = 16;
  localparam int STAGES = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_cia_adder #(
    .WIDTH (W),
    .BLOCK (4),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
    int           acc_stall;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   stalls      = 0;
  int   results     = 0;
  bit   prev_stall  = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: exact integer arithmetic on W+1 bits; overflow from the sign rule.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t        e;
    logic [W:0]  r;
    if (s) r = {1'b0, x} - {1'b0, y} + (W+1)'(1 << W);
    else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    if (s) e.ovf = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
    else   e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
    e.acc_cyc   = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h0000;
      1:       v = 16'hFFFF;
      2:       v = 16'h8000;
      3:       v = 16'h7FFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // One clock cycle: drive inputs after the falling edge, let them settle,
  // then score whatever handshakes the next rising edge will complete.
  task automatic cycle(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s, input logic ordy);
    exp_t e;
    bit   stall;
    @(negedge clk);
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = c;
    sub       = s;
    out_ready = ordy;
    #1;
    cyc++;
    check_value("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (prev_stall) check_value("stall_out_valid", 32'(out_valid), 32'd1);
    stall = out_valid && !out_ready;
    if (stall) begin
      stalls++;
      if (q.size() > 0) begin
        check_value("stall_sum", 32'(sum), 32'(q[0].sum));
        check_value("stall_cout", 32'(cout), 32'(q[0].cout));
      end
    end
    prev_stall = stall;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check_value("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        results++;
        $display("xfer %0d @cycle %0d: sum=%04h cout=%0b ovf=%0b", results, cyc, sum, cout, ovf);
        check_value("sum", 32'(sum), 32'(e.sum));
        check_value("cout", 32'(cout), 32'(e.cout));
        check_value("ovf", 32'(ovf), 32'(e.ovf));
        if (e.acc_stall == stalls) check_value("latency", 32'(cyc - e.acc_cyc), 32'(STAGES));
      end
    end
    if (in_valid && in_ready) begin
      e           = model(x, y, c, s);
      e.acc_cyc   = cyc;
      e.acc_stall = stalls;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_value("reset_out_valid", 32'(out_valid), 32'd0);
    check_value("reset_sum", 32'(sum), 32'd0);
    check_value("reset_cout", 32'(cout), 32'd0);
    check_value("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_value("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed corners: wrap, signed overflow, subtract, cin ignored on subtract
    cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle(4);

    // Back-to-back random operands
    for (int i = 0; i < 8; i++)
      cycle(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1);
    idle(4);

    // Alternating bubbles
    for (int i = 0; i < 10; i++)
      cycle(1'((i % 2) == 0), rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1);
    idle(4);

    // Fill the pipe, hold out_ready low, then release
    for (int i = 0; i < 9; i++)
      cycle(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0);
    idle(5);

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));
    idle(6);
    check_value("drain_empty", 32'(q.size()), 32'd0);

    // Reset with two operands in flight
    cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h4321, 16'h0101, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_sum", 32'(sum), 32'd0);
    check_value("rst_cout", 32'(cout), 32'd0);
    check_value("rst_ovf", 32'(ovf), 32'd0);
    q.delete();
    prev_stall = 1'b0;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_value("in_ready_after_release", 32'(in_ready), 32'd1);
    idle(6);

    // Still alive after reset
    cycle(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1);
    idle(4);
    check_value("final_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipelined_cia_adder.md
PIPELINED_CIA_ADDER -- requirements
Module: pipelined_cia_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a multiple of BLOCK and >= 4.
REQ-002 Parameter: BLOCK, default 4, bits per carry-increment block; LANES = WIDTH/BLOCK.
REQ-003 Parameter: STAGES, default 2, pipeline depth; SHALL divide LANES, range 1..LANES.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operands present.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 cin  input  1  carry in; ignored when sub=1.
REQ-012 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 sum  output  WIDTH  result.
REQ-016 cout  output  1  carry out (sub: 1 = no borrow).
REQ-017 ovf  output  1  signed two's-complement overflow.

Function
REQ-018 Transfer in when in_valid & in_ready; out when out_valid & out_ready.
REQ-019 Global advance: adv = !out_valid | out_ready; in_ready SHALL equal adv.
REQ-020 All stage registers (valid and data) SHALL load only when adv=1; when adv=0 every register, including sum/cout/ovf/out_valid, SHALL hold.
REQ-021 Stage k (0..STAGES-1) SHALL compute lanes k*LANES/STAGES .. (k+1)*LANES/STAGES-1 from the carry registered by stage k-1 (stage 0 uses effective cin), passing unprocessed operand bits and completed sum bits forward.
REQ-022 Each lane: BLOCK-bit ripple sum with carry-in 0, then half-adder increment chain by lane carry-in; lane carry-out = OR of both carries.
REQ-023 Latency: operand accepted at edge t, with adv held 1, SHALL appear with out_valid=1 after edge t+STAGES-1 completes, i.e. visible in the cycle following edge t+STAGES-1 (STAGES register levels).
REQ-024 Throughput: one result per cycle while out_ready=1 and in_valid=1.
REQ-025 sub=1: B inverted, lane-0 carry forced 1, cin ignored; sub registered with the operand.
REQ-026 ovf = carry into MSB XOR carry out of MSB.
REQ-027 Bubbles (in_valid=0 while adv=1) SHALL propagate as valid=0 stages; results SHALL never duplicate or drop.
REQ-028 Results SHALL leave in acceptance order.
REQ-029 Simultaneous out handshake and in handshake in same cycle SHALL both complete.
REQ-030 Full-width wrap: sum is modulo 2^WIDTH; cout reports carry.

Reset
REQ-031 rst_n low SHALL immediately clear all stage valid bits, out_valid, sum, cout, ovf and internal data to 0.
REQ-032 Reset mid-operation SHALL discard all in-flight operands; no result emitted after release for pre-reset inputs.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-034 Package cia_pkg SHALL hold mode constants (MODE_ADD=0, MODE_SUB=1) and an elaboration check function for WIDTH/BLOCK/STAGES legality.
REQ-035 One sub-module cia_block SHALL implement the BLOCK-bit lane (REQ-022), instantiated LANES times via generate.
REQ-036 Illegal parameters SHALL fail elaboration.

Verification (WIDTH=16, BLOCK=4, STAGES=2, out_ready=1 unless stated)
REQ-037 a=0xFFFF, b=0x0001, cin=0, sub=0 -> 2 cycles later sum=0x0000, cout=1, ovf=0.
REQ-038 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-039 Back-to-back 8 random operands -> 8 results on consecutive cycles, in order, matching reference model.
REQ-040 out_ready=0 for 5 cycles with pipe full -> in_ready=0, sum/out_valid stable; release -> no loss or duplication.
REQ-041 Assert rst_n=0 with 2 operands in flight -> outputs 0 immediately; after release no stale result appears.
REQ-042 Alternate in_valid 1/0 -> out_valid alternates with same spacing, latency 2.
